// File: rtl/sched_pkg.sv
// Shared definitions for the scheduler issue queue: command layout,
// default timing constants and the occupancy-state encoding.
package sched_pkg;

  // Command payload width; bit 0 carries the scheduler's second output.
  localparam int CMD_W      = 2;
  localparam int CMD_Q2_BIT = 0;

  // Default queue geometry and command-to-command spacing (tCCD).
  localparam int DEPTH_DEFAULT = 4;
  localparam int SKID_DEFAULT  = 2;
  localparam int TCCD_DEFAULT  = 4;

  // Width of the gap down-counter; holds GAP-1 for GAP up to 15.
  localparam int GAP_CNT_W = 4;

  // Occupancy classes, derived from the queue count.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_THRESH  = 2'd2,
    OCC_FULL    = 2'd3
  } occ_state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sched_gap_timer.sv
// Loadable down-counter enforcing spacing between issued commands.
// Reports whether the counter will be zero after the current edge so the
// owner can register its ready decision without an extra cycle of latency.
module sched_gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_next_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload on an issue, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign zero_next_o = (cnt_d == '0);

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sched_issue_queue.sv
// Issue queue between the scheduler hold register and the PHY command port.
// Buffers scheduled commands, spaces issues by at least GAP cycles, and
// raises stall early enough that commands already in flight still fit.
module sched_issue_queue
  import sched_pkg::*;
#(
  parameter int CMD_W = sched_pkg::CMD_W,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int SKID  = SKID_DEFAULT,
  parameter int GAP   = TCCD_DEFAULT,
  localparam int CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CMD_W-1:0] in_cmd,
  output logic             stall,
  output logic             out_valid,
  output logic [CMD_W-1:0] out_cmd,
  input  logic             out_ready,
  output logic             ovf,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]     DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]     THRESH_C   = CNT_W'(DEPTH - SKID);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD_C = GAP_CNT_W'(GAP - 1);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CMD_W-1:0] out_cmd_q, out_cmd_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;
  occ_state_e       occ_q, occ_d;
  logic             push_s, pop_s, full_s;
  logic             gap_zero_next_s;

  // Spacing timer: reloaded on every issue to the PHY.
  sched_gap_timer #(
    .W (GAP_CNT_W)
  ) u_gap_timer (
    .clk         (clk),
    .rst_n       (rst),
    .load_i      (pop_s),
    .load_val_i  (GAP_LOAD_C),
    .zero_next_o (gap_zero_next_s)
  );

  // Queue control: push/pop decisions, pointer and occupancy updates,
  // next head command and occupancy class.
  always_comb begin
    full_s = (count_q == DEPTH_C);
    pop_s  = out_valid_q && out_ready;
    // A full queue still accepts when the head leaves in the same cycle.
    push_s = in_valid && (!full_s || pop_s);
    ovf_d  = in_valid && full_s && !pop_s;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Head command for next cycle; the only way the write slot becomes
    // the head is a push into a queue that is empty after this cycle's pop.
    if (count_d != '0) begin
      if (push_s && (wr_ptr_q == rd_ptr_d)) begin
        out_cmd_d = in_cmd;
      end else begin
        out_cmd_d = mem_q[rd_ptr_d];
      end
    end else begin
      out_cmd_d = out_cmd_q;
    end

    if (count_d == DEPTH_C) begin
      occ_d = OCC_FULL;
    end else if (count_d >= THRESH_C) begin
      occ_d = OCC_THRESH;
    end else if (count_d == '0) begin
      occ_d = OCC_EMPTY;
    end else begin
      occ_d = OCC_PARTIAL;
    end

    out_valid_d = (count_d != '0) && gap_zero_next_s;
  end

  // Command storage; written at the write pointer on every accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= in_cmd;
    end
  end

  // Pointers, occupancy class and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_cmd_q   <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      occ_q       <= OCC_EMPTY;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_cmd_q   <= out_cmd_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      occ_q       <= occ_d;
    end
  end

  // Stall covers both the threshold band and the full state.
  assign stall     = (occ_q == OCC_THRESH) || (occ_q == OCC_FULL);
  assign out_valid = out_valid_q;
  assign out_cmd   = out_cmd_q;
  assign ovf       = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_sched_issue_queue.sv
// Bench for sched_issue_queue: two instances (GAP=4 and GAP=1) share the
// stimulus and are compared against a queue-based reference model.
module tb_sched_issue_queue;
  import sched_pkg::*;

  localparam int DEPTH = 4;
  localparam int SKID  = 2;
  localparam int GAP_A = 4;
  localparam int GAP_B = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_cmd;
  logic       out_ready;
  logic       stall_s     [2];
  logic       out_valid_s [2];
  logic       ovf_s       [2];
  logic [1:0] out_cmd_s   [2];
  logic [2:0] count_s     [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state.
  logic [1:0] mq  [2][$];
  logic [1:0] obs [2][$];
  int         last_pop  [2];
  bit         exp_stall [2];
  bit         exp_ovf   [2];

  always #5 clk = ~clk;

  sched_issue_queue #(.CMD_W(2), .DEPTH(DEPTH), .SKID(SKID), .GAP(GAP_A)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_cmd(in_cmd), .stall(stall_s[0]),
    .out_valid(out_valid_s[0]), .out_cmd(out_cmd_s[0]), .out_ready(out_ready),
    .ovf(ovf_s[0]), .count(count_s[0]));

  sched_issue_queue #(.CMD_W(2), .DEPTH(DEPTH), .SKID(SKID), .GAP(GAP_B)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_cmd(in_cmd), .stall(stall_s[1]),
    .out_valid(out_valid_s[1]), .out_cmd(out_cmd_s[1]), .out_ready(out_ready),
    .ovf(ovf_s[1]), .count(count_s[1]));

  function automatic int gap_of(int k);
    return (k == 0) ? GAP_A : GAP_B;
  endfunction

  // A command may issue once the queue holds one and GAP cycles passed since the last issue.
  function automatic bit exp_valid(int k);
    return (mq[k].size() != 0) && ((cyc - last_pop[k]) >= gap_of(k));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      last_pop[k]  = cyc - 16;
      exp_stall[k] = 1'b0;
      exp_ovf[k]   = 1'b0;
    end
  endtask

  // Advance one clock and apply the behavioural rules to the model; returns #1 after the edge.
  task automatic tick();
    bit pop, push, full;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      pop  = exp_valid(k) && out_ready;
      full = (mq[k].size() == DEPTH);
      push = in_valid && (!full || pop);
      exp_ovf[k] = in_valid && full && !pop;
      if (pop) begin
        void'(mq[k].pop_front());
        last_pop[k] = cyc;
      end
      if (push) mq[k].push_back(in_cmd);
      exp_stall[k] = (mq[k].size() >= (DEPTH - SKID));
    end
    cyc++;
    #1;
  endtask

  task automatic record_pops();
    for (int k = 0; k < 2; k++) begin
      if (out_valid_s[k] && out_ready) obs[k].push_back(out_cmd_s[k]);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_cmd = 2'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (count_s[k] !== 3'd3) begin n_fail++; $display("FAIL pre_reset_count[%0d]: got %0d expected 3", k, count_s[k]); end
    end
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({count_s[k], out_valid_s[k], out_cmd_s[k], stall_s[k], ovf_s[k]} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got count=%0d valid=%b cmd=%b stall=%b ovf=%b expected all 0",
                 k, count_s[k], out_valid_s[k], out_cmd_s[k], stall_s[k], ovf_s[k]);
      end
    end
    model_reset();
    @(negedge clk) rst = 1'b1;
    in_cmd = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (out_valid_s[k] !== 1'b1 || out_cmd_s[k] !== 2'b01 || count_s[k] !== 3'd1) begin
        n_fail++;
        $display("FAIL single_cmd[%0d]: got valid=%b cmd=%b count=%0d expected 1 01 1", k, out_valid_s[k], out_cmd_s[k], count_s[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (out_valid_s[k] !== 1'b0 || count_s[k] !== 3'd0) begin
        n_fail++;
        $display("FAIL single_pop[%0d]: got valid=%b count=%0d expected 0 0", k, out_valid_s[k], count_s[k]);
      end
    end
  endtask

  task automatic test_gap();
    int pop_cyc[$];
    logic [1:0] pop_val[$];
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (4) tick();
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 3);
      in_cmd   = 2'(c + 1);
      if (out_valid_s[0]) begin pop_cyc.push_back(c); pop_val.push_back(out_cmd_s[0]); end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (out_valid_s[k] !== exp_valid(k) || count_s[k] !== 3'(mq[k].size())) begin
          n_fail++;
          $display("FAIL gap_cycle[%0d] c=%0d: got valid=%b count=%0d expected %b %0d", k, c, out_valid_s[k], count_s[k], exp_valid(k), mq[k].size());
        end
      end
    end
    in_valid = 1'b0;
    n_chk++;
    if (pop_cyc.size() != 3) begin
      n_fail++; $display("FAIL gap_pop_count: got %0d expected 3", pop_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (pop_cyc[i] != 1 + 4 * i || pop_val[i] !== 2'(i + 1)) begin
          n_fail++;
          $display("FAIL gap_pop%0d: got cycle=%0d cmd=%b expected cycle=%0d cmd=%0d", i, pop_cyc[i], pop_val[i], 1 + 4 * i, i + 1);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit s1 = 1'b0, s2 = 1'b0, ovf_seen = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = !s2;
      in_cmd   = 2'(c);
      tick();
      ovf_seen |= ovf_s[0];
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (stall_s[k] !== exp_stall[k] || count_s[k] !== 3'(mq[k].size())) begin
          n_fail++;
          $display("FAIL stall_cycle[%0d] c=%0d: got stall=%b count=%0d expected %b %0d", k, c, stall_s[k], count_s[k], exp_stall[k], mq[k].size());
        end
      end
      s2 = s1; s1 = stall_s[0];
    end
    in_valid = 1'b0;
    n_chk++;
    if (count_s[0] !== 3'd3 || ovf_seen || stall_s[0] !== 1'b1) begin
      n_fail++; $display("FAIL stall_landing: got count=%0d ovf_seen=%b stall=%b expected 3 0 1", count_s[0], ovf_seen, stall_s[0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (stall_s[k] !== exp_stall[k] || out_valid_s[k] !== exp_valid(k)) begin
          n_fail++;
          $display("FAIL stall_drain[%0d] c=%0d: got stall=%b valid=%b expected %b %b", k, c, stall_s[k], out_valid_s[k], exp_stall[k], exp_valid(k));
        end
      end
    end
  endtask

  task automatic test_full_pushpop();
    logic [1:0] want [5];
    want = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin in_valid = 1'b1; in_cmd = 2'(c); tick(); end
    in_valid = 1'b0;
    repeat (4) tick();
    obs[0].delete(); obs[1].delete();
    in_valid = 1'b1; in_cmd = 2'b10; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (count_s[k] !== 3'd4 || out_valid_s[k] !== 1'b1) begin
        n_fail++; $display("FAIL full_before[%0d]: got count=%0d valid=%b expected 4 1", k, count_s[k], out_valid_s[k]);
      end
    end
    record_pops();
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (count_s[k] !== 3'd4 || ovf_s[k] !== 1'b0) begin
        n_fail++; $display("FAIL full_pushpop[%0d]: got count=%0d ovf=%b expected 4 0", k, count_s[k], ovf_s[k]);
      end
    end
    for (int c = 0; c < 24; c++) begin record_pops(); tick(); end
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (obs[k].size() != 5) begin
        n_fail++; $display("FAIL full_order_len[%0d]: got %0d expected 5", k, obs[k].size());
      end else begin
        for (int i = 0; i < 5; i++) begin
          n_chk++;
          if (obs[k][i] !== want[i]) begin
            n_fail++; $display("FAIL full_order[%0d][%0d]: got %b expected %b", k, i, obs[k][i], want[i]);
          end
        end
      end
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin in_valid = 1'b1; in_cmd = 2'b00; tick(); end
    in_cmd = 2'b11;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (ovf_s[k] !== 1'b1 || count_s[k] !== 3'd4) begin
        n_fail++; $display("FAIL ovf_pulse[%0d]: got ovf=%b count=%0d expected 1 4", k, ovf_s[k], count_s[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (ovf_s[k] !== 1'b0 || count_s[k] !== 3'd4) begin
        n_fail++; $display("FAIL ovf_single[%0d]: got ovf=%b count=%0d expected 0 4", k, ovf_s[k], count_s[k]);
      end
    end
    obs[0].delete(); obs[1].delete();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin record_pops(); tick(); end
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (obs[k].size() != 4 || (4'(obs[k].sum() with (int'(item)))) != 4'd0) begin
        n_fail++; $display("FAIL ovf_dropped[%0d]: got %0d pops, nonzero payload seen=%b expected 4 pops of 0", k, obs[k].size(), obs[k].sum() with (int'(item)) != 0);
      end
    end
  endtask

  task automatic test_wrap();
    bit s1 = 1'b0, s2 = 1'b0;
    int sent = 0;
    obs[0].delete(); obs[1].delete();
    for (int c = 0; c < 400 && obs[1].size() < 10; c++) begin
      in_valid  = (sent < 10) && !s2 && ($urandom_range(0, 3) != 0);
      in_cmd    = 2'(sent % 4);
      out_ready = 1'($urandom_range(0, 1));
      record_pops();
      if (in_valid) sent++;
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (count_s[k] !== 3'(mq[k].size()) || out_valid_s[k] !== exp_valid(k) || stall_s[k] !== exp_stall[k]
            || ovf_s[k] !== exp_ovf[k] || (exp_valid(k) && out_cmd_s[k] !== mq[k][0])) begin
          n_fail++;
          $display("FAIL wrap_cycle[%0d] c=%0d: got count=%0d valid=%b stall=%b ovf=%b cmd=%b expected %0d %b %b %b",
                   k, c, count_s[k], out_valid_s[k], stall_s[k], ovf_s[k], out_cmd_s[k], mq[k].size(), exp_valid(k), exp_stall[k], exp_ovf[k]);
        end
      end
      n_chk++;
      if (count_s[1] > 3'd4) begin n_fail++; $display("FAIL wrap_bound: got count=%0d expected <= 4", count_s[1]); end
      s2 = s1; s1 = stall_s[1];
    end
    in_valid = 1'b0;
    n_chk++;
    if (obs[1].size() != 10) begin
      n_fail++; $display("FAIL wrap_len: got %0d pops expected 10 (cycle budget)", obs[1].size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_chk++;
        if (obs[1][i] !== 2'(i % 4)) begin
          n_fail++; $display("FAIL wrap_order[%0d]: got %b expected %0d", i, obs[1][i], i % 4);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_cmd = 2'b00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    test_reset();
    test_gap();
    test_stall();
    test_full_pushpop();
    test_overflow();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
